// File: rtl/fetch_sequencer_if.sv
// Handshake and datapath-control bundle between the fetch sequencer and the PC/ROM/fetch-register datapath.
interface fetch_sequencer_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NIB_W  = 4;

    logic              start;
    logic [BYTE_W-1:0] program_byte;
    logic [NIB_W-1:0]  instr;
    logic [NIB_W-1:0]  oprnd;
    logic              zero;
    logic              exec_ready;
    logic              en1;
    logic              en2;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              exec_valid;
    logic              halted;
    logic              busy;

    modport master (
        input  start, program_byte, instr, oprnd, zero, exec_ready,
        output en1, en2, load, load_addr, exec_valid, halted, busy
    );

    modport slave (
        output start, program_byte, instr, oprnd, zero, exec_ready,
        input  en1, en2, load, load_addr, exec_valid, halted, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode control FSM: drives PC and fetch-register enables, resolves JMP/JZ/HLT,
// and hands all other instructions to the execute stage via valid/ready.
module fetch_sequencer (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NIB_W  = 4;

    localparam logic [NIB_W-1:0] OP_JMP = 4'hF;
    localparam logic [NIB_W-1:0] OP_JZ  = 4'hE;
    localparam logic [NIB_W-1:0] OP_HLT = 4'hD;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_JLO    = 3'd4;
    localparam logic [2:0] S_JLD    = 3'd5;
    localparam logic [2:0] S_SKIP   = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic [2:0]        state, next_state;
    logic [NIB_W-1:0]  hi_nib, hi_nib_next;
    logic [ADDR_W-1:0] load_addr_next;
    logic              en1_next, en2_next, load_next, valid_next, halted_next, busy_next;

    // Next state plus the Moore outputs of that state, so outputs come straight off flops.
    always_comb begin
        next_state     = state;
        hi_nib_next    = hi_nib;
        load_addr_next = bus.load_addr;
        case (state)
            S_IDLE:   if (bus.start) next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (bus.instr == OP_HLT) begin
                    next_state = S_HALT;
                end else if (bus.instr == OP_JMP || (bus.instr == OP_JZ && bus.zero)) begin
                    next_state  = S_JLO;
                    hi_nib_next = bus.oprnd;
                end else if (bus.instr == OP_JZ) begin
                    next_state = S_SKIP;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC:   if (bus.exec_ready) next_state = S_FETCH;
            S_JLO: begin
                next_state     = S_JLD;
                load_addr_next = {hi_nib, bus.program_byte};
            end
            S_JLD:    next_state = S_FETCH;
            S_SKIP:   next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase

        en1_next    = (next_state == S_FETCH) || (next_state == S_SKIP);
        en2_next    = (next_state == S_FETCH);
        load_next   = (next_state == S_JLD);
        valid_next  = (next_state == S_EXEC);
        halted_next = (next_state == S_HALT);
        busy_next   = (next_state != S_IDLE) && (next_state != S_HALT);
    end

    // Reset clears every output at once, so a load pulse in flight is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            hi_nib         <= '0;
            bus.load_addr  <= '0;
            bus.en1        <= 1'b0;
            bus.en2        <= 1'b0;
            bus.load       <= 1'b0;
            bus.exec_valid <= 1'b0;
            bus.halted     <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= next_state;
            hi_nib         <= hi_nib_next;
            bus.load_addr  <= load_addr_next;
            bus.en1        <= en1_next;
            bus.en2        <= en2_next;
            bus.load       <= load_next;
            bus.exec_valid <= valid_next;
            bus.halted     <= halted_next;
            bus.busy       <= busy_next;
        end
    end
endmodule
